// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------------------------
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
//   A setpoint entered as packed BCD digits becomes an unsigned binary value that can be
//   compared directly against raw ADC codes.
//
// Parameters
//   DIGITS        number of packed BCD digits in bcd_in (4 bits each)
//   BIN_W         width of binary_out; also the number of shift steps per conversion
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      bcd_in is valid
//   in_ready      converter can accept an input (decoded from state)
//   bcd_in        packed digits, [3:0] = ones, [7:4] = tens, ...
//   out_valid     binary_out and flags are valid
//   out_ready     consumer takes the result
//   binary_out    converted value (0 when a flag is set)
//   err_digit     some input digit was > 9
//   err_overflow  value does not fit in BIN_W bits
// ---------------------------------------------------------------------------------------------
module bcd_to_binary_seq #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      binary_out,
   output logic                  err_digit,
   output logic                  err_overflow
);

   localparam int unsigned BcdW  = 4 * DIGITS;
   localparam int unsigned WorkW = BcdW + BIN_W;
   localparam int unsigned CntW  = $clog2(BIN_W + 1);

   // StCheck inspects the registered digits; StBad delays the digit error by one edge so the
   // error result appears on the second edge after the accept.
   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StBad,
      StConv,
      StDone
   } state_e;

   state_e              r_state, w_state_d;
   logic [WorkW-1:0]    r_work, w_work_d;
   logic [CntW-1:0]     r_cnt, w_cnt_d;
   logic                r_out_valid, w_out_valid_d;
   logic [BIN_W-1:0]    r_binary, w_binary_d;
   logic                r_err_digit, w_err_digit_d;
   logic                r_err_ovf, w_err_ovf_d;

   logic                w_bad_digit;
   logic [WorkW-1:0]    w_step;
   logic [CntW-1:0]     w_cnt_inc;

   // One reverse double-dabble step: shift right, then pull every digit that landed at >= 8
   // back by 3 (the inverse of the add-3 correction in the forward direction).
   function automatic logic [WorkW-1:0] f_dabble(input logic [WorkW-1:0] work);
      logic [WorkW-1:0] s;
      s = work >> 1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (s[BIN_W + 4*d + 3]) begin
            s[BIN_W + 4*d +: 4] = s[BIN_W + 4*d +: 4] - 4'd3;
         end
      end
      return s;
   endfunction

   function automatic logic f_any_bad(input logic [BcdW-1:0] bcd);
      logic bad;
      bad = 1'b0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   assign w_bad_digit = f_any_bad(r_work[WorkW-1 -: BcdW]);
   assign w_step      = f_dabble(r_work);
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign in_ready    = (r_state == StIdle);

   always_comb begin
      w_state_d     = r_state;
      w_work_d      = r_work;
      w_cnt_d       = r_cnt;
      w_out_valid_d = r_out_valid;
      w_binary_d    = r_binary;
      w_err_digit_d = r_err_digit;
      w_err_ovf_d   = r_err_ovf;

      unique case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_work_d      = {bcd_in, {BIN_W{1'b0}}};
               w_err_digit_d = 1'b0;
               w_err_ovf_d   = 1'b0;
               w_state_d     = StCheck;
            end
         end
         StCheck: begin
            w_cnt_d   = '0;
            w_state_d = w_bad_digit ? StBad : StConv;
         end
         StBad: begin
            w_out_valid_d = 1'b1;
            w_binary_d    = '0;
            w_err_digit_d = 1'b1;
            w_err_ovf_d   = 1'b0;
            w_state_d     = StDone;
         end
         StConv: begin
            w_work_d = w_step;
            w_cnt_d  = w_cnt_inc;
            if (w_cnt_inc == CntW'(BIN_W)) begin
               w_out_valid_d = 1'b1;
               w_state_d     = StDone;
               // Anything left in the BCD part means the value needs more than BIN_W bits.
               if (w_step[WorkW-1 -: BcdW] == '0) begin
                  w_binary_d  = w_step[BIN_W-1:0];
                  w_err_ovf_d = 1'b0;
               end else begin
                  w_binary_d  = '0;
                  w_err_ovf_d = 1'b1;
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               w_out_valid_d = 1'b0;
               w_state_d     = StIdle;
            end
         end
         default: begin
            w_state_d     = StIdle;
            w_out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_work      <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_binary    <= '0;
         r_err_digit <= 1'b0;
         r_err_ovf   <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_work      <= w_work_d;
         r_cnt       <= w_cnt_d;
         r_out_valid <= w_out_valid_d;
         r_binary    <= w_binary_d;
         r_err_digit <= w_err_digit_d;
         r_err_ovf   <= w_err_ovf_d;
      end
   end

   assign out_valid    = r_out_valid;
   assign binary_out   = r_binary;
   assign err_digit    = r_err_digit;
   assign err_overflow = r_err_ovf;

endmodule
